// File: rtl/posit_decode_pipe.sv
// rtl/posit_decode_pipe.sv - two-stage pipelined posit<N,ES> field decoder
// S1 registers sign, special flags and magnitude; S2 decodes regime/exp/frac into the output registers.
module posit_decode_pipe #(
  parameter int N = 32,
  parameter int ES = 2,
  localparam int RW = $clog2(N) + 1,
  localparam int FW = N - 3 - ES,
  localparam int EW = (ES > 0) ? ES : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_nar,
  output logic signed [RW-1:0] out_regime,
  output logic [EW-1:0]        out_exp,
  output logic signed [RW+ES-1:0] out_scale,
  output logic [FW-1:0]        out_frac
);

  logic         s1_valid;
  logic         s1_sign;
  logic         s1_zero;
  logic         s1_nar;
  logic [N-1:0] s1_mag;

  logic                    s2_ready;
  logic [N-2:0]            body;
  logic [N-2:0]            run_bits;
  logic [N-2:0]            lead_oh;
  logic [RW-1:0]           run_len;
  logic [N-2:0]            shifted;
  logic                    r0;
  logic signed [RW-1:0]    regime_c;
  logic [EW-1:0]           exp_c;
  logic signed [RW+ES-1:0] scale_c;
  logic [FW-1:0]           frac_c;
  logic                    special;
  logic                    unused_bits;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  assign body = s1_mag[N-2:0];
  assign r0 = body[N-2];
  // Invert a ones-run so the run always ends at the first set bit.
  assign run_bits = r0 ? ~body : body;

  always_comb begin
    lead_oh = '0;
    for (int i = 0; i < N-1; i++) begin
      lead_oh[i] = run_bits[i] & ~|(run_bits >> (i + 1));
    end
    run_len = (run_bits == '0) ? RW'(N-1) : '0;
    for (int i = 0; i < N-1; i++) begin
      if (lead_oh[i]) run_len = run_len | RW'(N-2-i);
    end
  end

  // Shifting out the run plus its terminator leaves exp then fraction at the top.
  assign shifted  = body << (run_len + RW'(1));
  assign regime_c = r0 ? $signed(run_len - RW'(1)) : $signed(-run_len);
  assign frac_c   = shifted[N-2-ES -: FW];

  generate
    if (ES > 0) begin : g_exp
      assign exp_c   = shifted[N-2 -: EW];
      assign scale_c = {regime_c, exp_c};
    end else begin : g_noexp
      assign exp_c   = 1'b0;
      assign scale_c = regime_c;
    end
  endgenerate

  assign special     = s1_zero || s1_nar;
  assign unused_bits = s1_mag[N-1] ^ (^shifted[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_zero    <= 1'b0;
      s1_nar     <= 1'b0;
      s1_mag     <= '0;
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      out_zero   <= 1'b0;
      out_nar    <= 1'b0;
      out_regime <= '0;
      out_exp    <= '0;
      out_scale  <= '0;
      out_frac   <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sign <= in_data[N-1];
        s1_zero <= (in_data == '0);
        s1_nar  <= (in_data == {1'b1, {(N-1){1'b0}}});
        s1_mag  <= in_data[N-1] ? -in_data : in_data;
      end
      if (s2_ready) out_valid <= s1_valid;
      if (s2_ready && s1_valid) begin
        out_sign   <= s1_sign;
        out_zero   <= s1_zero;
        out_nar    <= s1_nar;
        out_regime <= special ? '0 : regime_c;
        out_exp    <= special ? '0 : exp_c;
        out_scale  <= special ? '0 : scale_c;
        out_frac   <= special ? '0 : frac_c;
      end
    end
  end

endmodule

// File: doc/posit_decode_pipe.md
Name: posit_decode_pipe

Overview:
Pipelined, parametrised posit field decoder. It takes a posit<N,ES> word and splits it into sign, special flags, regime, exponent, scale and a left-aligned fraction, with the hidden bit omitted. The regime/leading-run decoder is generalised to any N and ES. Two register stages with valid/ready backpressure let it sit directly in front of the posit multiply/add datapaths.

Parameters:
N, 32, posit word width; N >= ES+5
ES, 2, exponent field width; 0 allowed (then out_exp is tied to 0 and kept 1 bit wide)
RW, $clog2(N)+1, signed regime width (derived, not overridden)
FW, N-3-ES, fraction width = maximum fraction bits (derived)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word this cycle
in_data  in  N  posit word
out_valid  out  1  decoded result valid
out_ready  in  1  consumer accepts the result
out_sign  out  1  posit sign bit
out_zero  out  1  input was 0x0
out_nar  out  1  input was NaR (1 followed by zeros)
out_regime  out  RW  signed regime value k
out_exp  out  max(ES,1)  exponent field; missing (truncated) bits read as 0
out_scale  out  RW+ES  signed; regime*2^ES + exp
out_frac  out  FW  fraction bits, MSB-aligned, zero-filled

Behaviour:
- Reset: asynchronous, active-low, on rst_n. All stage valid flags and all output registers clear to 0. in_ready = 1 after reset.
- Transfer rule: a transfer happens when valid && ready in the same cycle, on both interfaces.
- Stage 1 (S1), on accept:
  - register sign = in_data[N-1].
  - register zero and nar flags.
  - register magnitude word: two's complement of in_data when sign=1, else in_data.
- Stage 2 (S2), output registers, from S1:
  - r0 = mag[N-2]. Run length L = count of consecutive bits equal to r0, from bit N-2 downward; 1 <= L <= N-1.
  - regime = L-1 when r0=1; regime = -L when r0=0.
  - The terminating bit (if present) is skipped. The next ES bits form exp; bits past bit 0 read as 0. The remaining bits are left-aligned into out_frac, zero-filled.
  - Implementation: one-hot leading-change vector plus a left shifter; no iterative or multi-cycle logic.
  - out_scale = {regime, exp} (regime shifted left by ES, OR exp). This is sign-correct because exp >= 0.
- Zero and NaR: out_regime, out_exp, out_scale and out_frac are forced to 0. out_sign = 0 for zero and 1 for NaR.
- Latency: 2 cycles from accept to out_valid at full throughput. Throughput is 1 word per cycle.
- Backpressure: S2 holds while out_valid && !out_ready. S1 advances only when S2 is empty or draining.
  - in_ready = !s1_valid || !s2_valid || out_ready. No combinational path from in_valid to in_ready.
  - Outputs are stable while out_valid && !out_ready.
  - No word is dropped or duplicated under any out_ready pattern.
- Simultaneous events: accept and drain in the same cycle both take effect; the pipeline shifts with no bubble.
- Reset mid-operation: in-flight words are discarded and out_valid drops asynchronously.

Test Plan:
- N=16, ES=1, in_data=0x4000 -> 2 cycles later: out_sign=0, regime=0, exp=0, scale=0, frac=0.
- N=16, ES=1: 0x4800 -> regime=0, exp=0, frac=12'h800.
  - 0x5000 -> exp=1, scale=1.
  - 0xC000 -> sign=1, regime=0, scale=0.
- N=16, ES=1 boundaries:
  - 0x7FFF -> regime=14, scale=28, frac=0.
  - 0x7FFE -> regime=13, exp=0 (truncated), scale=26.
  - 0x0001 -> regime=-14, scale=-28.
- Specials, N=32, ES=2:
  - 0x00000000 -> out_zero=1, all fields 0.
  - 0x80000000 -> out_nar=1, out_sign=1, all fields 0.
- Backpressure: stream 8 random words with in_valid=1 while out_ready toggles 1,0,0,1,...
  - Outputs must match the reference model in order, with no loss or duplication.
  - in_ready must fall when both stages are full and out_ready=0.
- Reset mid-stream: assert rst_n=0 with 2 words in flight -> out_valid=0 immediately. After release, in_ready=1 and the next word decodes with 2-cycle latency.
